mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. Acts as a responder on the processor's data-memory bus, in parallel with dmem.
- It decodes its own address window. Stores to the TXDATA register queue bytes in a small FIFO, and an FSM serializes them as 8N1 on `tx`.
- Loads return status and configuration.
- The top level selects `rd` from this block over dmem when `sel` is high.

Parameters:
- BASE, 32'h0000_0080: word-aligned base address of the 16-byte register window.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2, ≥2.
- DEFAULT_DIV, 16: reset value of BAUDDIV, in clock cycles per bit.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- we, input, 1: store strobe (MemWrite).
- a, input, 32: byte address (DataAdr).
- wd, input, 32: store data (WriteData).
- rd, output, 32: combinational read data.
- sel, output, 1: combinational; high when a[31:4] == BASE[31:4].
- tx, output, 1: serial line, registered, idles high.

Behaviour:
- Register map (a[3:2]); reads are combinational and side-effect free:
  - 0 TXDATA
    - Write: push wd[7:0].
    - Read: 0.
  - 1 STATUS, read:
    - bit0 full.
    - bit1 empty.
    - bit2 busy (FSM not IDLE).
    - bit3 overflow (sticky).
    - bits[6:4] FIFO count; count = FIFO_DEPTH reads as FIFO_DEPTH mod 8.
    - Others 0.
  - 1 STATUS, write: wd[3]=1 clears overflow; other bits ignored.
  - 2 BAUDDIV
    - Read/write bits[15:0].
    - Written values below 2 are stored as 2.
  - 3: reserved; reads 0, writes ignored.
- Address decode:
  - sel=0: rd=0 and writes are ignored.
  - a[1:0] is ignored.
- Reset values (asynchronous):
  - tx=1, FIFO empty (count 0), overflow=0.
  - BAUDDIV=DEFAULT_DIV, FSM=IDLE.
  - Shift register and bit counters are 0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push on a write to TXDATA when not full.
  - A push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle; fullness is sampled before the edge.
  - Simultaneous push (not full) and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If FIFO non-empty at an edge: pop the head into the shift register, latch BAUDDIV into the frame divider, clear the baud counter, go to START.
  - START:
    - tx=0 for exactly div cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[0] for div cycles, then shift right and increment the index.
    - After the 8th bit (index 7 done), go to STOP.
    - LSB first.
  - STOP:
    - tx=1 for div cycles.
    - At the end: if FIFO non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- tx timing:
  - tx is registered from state/shift, so line changes occur at the same edge as state changes.
  - One frame is 10*div cycles.
- Latency: a store accepted at edge E0 gives count=1 after E0. At E1, FSM pops, busy=1, and tx falls. The first data bit starts at E1+div.
- Divider:
  - A BAUDDIV write mid-frame does not affect the current frame.
  - It applies from the next frame start.
- Reset mid-frame: tx returns high immediately, the FIFO contents are discarded, and no partial frame resumes.

Test Plan:
- Reset then idle 50 cycles → tx=1, STATUS read = 0x02, BAUDDIV read = 16, sel=0 for a=0x60.
- BAUDDIV=4, store 0x55 to 0x80 → tx low 4 cycles starting the edge after the store. Bits then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high 4 cycles. busy=0 after 40 cycles; STATUS = 0x02.
- BAUDDIV=2, four back-to-back stores 0x01,0x02,0x03,0x04:
  - Immediately after the 4th store: count=3 (first byte already popped), busy=1.
  - Frames are contiguous: 80 cycles total, no idle high between stop and next start.
  - Decoded bytes are 01,02,03,04 in order.
- BAUDDIV=8, six stores in consecutive cycles → bytes 1–5 accepted (one popped at the first edge plus 4 queued); the 6th is dropped.
  - STATUS bit3=1, bit0=1.
  - Writing STATUS with 0x8 clears bit3 only.
  - Exactly 5 frames are emitted.
- Write BAUDDIV=3 during a frame at div=4 → current frame stays 40 cycles, the next queued frame is 30 cycles. Writing BAUDDIV=0 reads back 2.
- Assert reset mid-DATA with 2 bytes queued → tx=1 the same cycle (asynchronous), STATUS=0x02 after release, no further frames.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes a 16-byte register window on the
// data-memory bus, queues TXDATA stores in a small FIFO and serializes them on tx.
module mmio_uart_tx #(
  parameter logic [31:0] BASE        = 32'h0000_0080,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   bauddiv;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [15:0]   baud_cnt, baud_cnt_n;
  logic [15:0]   div_q, div_q_n;
  logic          tx_n;
  logic          pop;

  logic          full, empty, busy, bit_end;
  logic          wr_txdata, wr_status, wr_baud, push;
  logic [31:0]   count_ext;
  logic          unused;

  // A divider below 2 cannot produce a distinct bit period, so it is clamped.
  function automatic logic [15:0] sat_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  assign sel       = (a[31:4] == BASE[31:4]);
  assign wr_txdata = we && sel && (a[3:2] == 2'd0);
  assign wr_status = we && sel && (a[3:2] == 2'd1);
  assign wr_baud   = we && sel && (a[3:2] == 2'd2);

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign push      = wr_txdata && !full;
  assign bit_end   = (baud_cnt == div_q - 16'd1);
  assign count_ext = 32'(count);
  assign unused    = ^{a[1:0], wd[31:16], count_ext[31:3]};

  always_comb begin
    rd = '0;
    if (sel) begin
      case (a[3:2])
        2'd1:    rd = {25'b0, count_ext[2:0], ovf, busy, empty, full};
        2'd2:    rd = {16'b0, bauddiv};
        default: rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      bauddiv <= DEFAULT_DIV;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Fullness is the pre-edge value, so a same-cycle pop does not rescue the push.
      if (wr_txdata && full)
        ovf <= 1'b1;
      else if (wr_status && wd[3])
        ovf <= 1'b0;
      if (wr_baud) bauddiv <= sat_div(wd[15:0]);
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    baud_cnt_n = baud_cnt;
    div_q_n    = div_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_n    = START;
          shift_n    = fifo_mem[rptr];
          div_q_n    = bauddiv;
          baud_cnt_n = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          bit_idx_n  = '0;
          baud_cnt_n = '0;
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          bit_idx_n  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
            shift_n = fifo_mem[rptr];
            div_q_n = bauddiv;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= DEFAULT_DIV;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      baud_cnt <= baud_cnt_n;
      div_q    <= div_q_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: the tx line is logged every cycle and
// compared with frames computed directly from byte values and dividers.
module tb_mmio_uart_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  localparam int LOGN = 16384;
  logic txlog [0:LOGN-1];

  mmio_uart_tx #(.BASE(32'h0000_0080), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < LOGN) txlog[cyc] <= tx;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Line level at cycle k of an 8N1 frame of byte b with div cycles per bit.
  function automatic logic exp_line(input logic [7:0] b, input int d, input int k);
    int slot;
    slot = k / d;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic logic [31:0] exp_status(input int cnt, input bit bsy, input bit ov);
    logic [31:0] s;
    s = '0;
    s[0] = (cnt == 4);
    s[1] = (cnt == 0);
    s[2] = bsy;
    s[3] = ov;
    s[6:4] = 3'(cnt % 8);
    return s;
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int en);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1;
    en = cyc;
    we = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    we = 1'b0; a = addr;
    #1;
    data = rd;
  endtask

  task automatic wait_cyc(input int n);
    for (int g = 0; g < 5000 && cyc < n; g++) @(negedge clk);
    tests++;
    if (cyc < n) begin
      fails++;
      $display("FAIL wait_cyc: timed out at cycle %0d, want cycle %0d", cyc, n);
    end
  endtask

  task automatic check_frames(input string name, input int start, input logic [7:0] bq[$],
                              input int dq[$], input int idle);
    int t;
    int stop;
    int bad;
    stop = start;
    foreach (dq[i]) stop += 10 * dq[i];
    wait_cyc(stop + idle + 1);
    @(negedge clk);
    tests++;
    if (txlog[start-1] !== 1'b1) begin
      fails++;
      $display("FAIL %s pre-idle: tx=%b before frame start, want 1", name, txlog[start-1]);
    end
    t = start;
    foreach (bq[i]) begin
      bad = -1;
      for (int k = 0; k < 10 * dq[i]; k++)
        if (bad < 0 && txlog[t+k] !== exp_line(bq[i], dq[i], k)) bad = k;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL %s frame %0d (byte %02h div %0d): cycle %0d tx=%b, want %b",
                 name, i, bq[i], dq[i], bad, txlog[t+bad], exp_line(bq[i], dq[i], bad));
      end
      t += 10 * dq[i];
    end
    bad = -1;
    for (int k = 0; k < idle; k++) if (bad < 0 && txlog[stop+k] !== 1'b1) bad = k;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s post-idle: tx=0 at %0d cycles after last frame, want 1", name, bad);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    int start, bad, e;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = cyc;
    repeat (51) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 50; k++) if (txlog[start+k] !== 1'b1) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset idle: %0d low cycles, want 0", bad); end
    rdreg(32'h84, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL reset status: got %h want %h", v, 32'h2); end
    rdreg(32'h88, v);
    tests++;
    if (v !== 32'd16) begin fails++; $display("FAIL reset bauddiv: got %0d want 16", v); end
    rdreg(32'h80, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL txdata read: got %h want 0", v); end
    rdreg(32'h8F, v);
    tests++;
    if (v !== 32'h0 || sel !== 1'b1) begin
      fails++; $display("FAIL reserved read: got rd=%h sel=%b want rd=0 sel=1", v, sel);
    end
    wr(32'h68, 32'd5, e);
    rdreg(32'h60, v);
    tests++;
    if (sel !== 1'b0 || v !== 32'h0) begin
      fails++; $display("FAIL decode 0x60: got sel=%b rd=%h want sel=0 rd=0", sel, v);
    end
    rdreg(32'h88, v);
    tests++;
    if (v !== 32'd16) begin fails++; $display("FAIL outside write: bauddiv got %0d want 16", v); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    logic [7:0] bq[$];
    int dq[$];
    int e0, e;
    wr(32'h88, 32'd4, e);
    wr(32'h80, 32'h55, e0);
    rdreg(32'h84, v);
    tests++;
    if (v !== exp_status(1, 0, 0)) begin
      fails++; $display("FAIL basic status after store: got %h want %h", v, exp_status(1, 0, 0));
    end
    bq.push_back(8'h55); dq.push_back(4);
    check_frames("basic", e0 + 1, bq, dq, 5);
    rdreg(32'h84, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL basic status after frame: got %h want 2", v); end
  endtask

  task automatic test_random;
    logic [7:0] bq[$];
    int dq[$];
    int d, e0, e;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      bq.delete(); dq.delete();
      d = $urandom_range(2, 5);
      b = 8'($urandom);
      wr(32'h88 | 32'($urandom_range(0, 3)), ($urandom & 32'hFFFF_0000) | 32'(d), e);
      wr(32'h80 | 32'($urandom_range(0, 3)), ($urandom & 32'hFFFF_FF00) | 32'(b), e0);
      bq.push_back(b); dq.push_back(d);
      check_frames("random", e0 + 1, bq, dq, 3);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0] bq[$];
    int dq[$];
    int e0, e;
    wr(32'h88, 32'd2, e);
    wr(32'h80, 32'h01, e0);
    for (int i = 2; i <= 4; i++) wr(32'h80, 32'(i), e);
    rdreg(32'h84, v);
    tests++;
    if (v !== exp_status(3, 1, 0)) begin
      fails++; $display("FAIL b2b status: got %h want %h", v, exp_status(3, 1, 0));
    end
    for (int i = 1; i <= 4; i++) begin bq.push_back(8'(i)); dq.push_back(2); end
    check_frames("b2b", e0 + 1, bq, dq, 5);
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [7:0] bq[$];
    logic [7:0] b;
    int dq[$];
    int e0, e;
    wr(32'h88, 32'd8, e);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i == 0) wr(32'h80, 32'(b), e0); else wr(32'h80, 32'(b), e);
      if (i < 5) begin bq.push_back(b); dq.push_back(8); end
    end
    rdreg(32'h84, v);
    tests++;
    if (v !== exp_status(4, 1, 1)) begin
      fails++; $display("FAIL overflow status: got %h want %h", v, exp_status(4, 1, 1));
    end
    wr(32'h84, 32'h8, e);
    rdreg(32'h84, v);
    tests++;
    if (v !== exp_status(4, 1, 0)) begin
      fails++; $display("FAIL overflow clear: got %h want %h", v, exp_status(4, 1, 0));
    end
    check_frames("overflow", e0 + 1, bq, dq, 40);
  endtask

  task automatic test_divchange;
    logic [31:0] v;
    logic [7:0] bq[$];
    int dq[$];
    int e0, e;
    wr(32'h88, 32'd4, e);
    bq.push_back(8'($urandom)); bq.push_back(8'($urandom));
    dq.push_back(4); dq.push_back(3);
    wr(32'h80, 32'(bq[0]), e0);
    wr(32'h80, 32'(bq[1]), e);
    wait_cyc(e0 + 10);
    wr(32'h88, 32'd3, e);
    check_frames("divchange", e0 + 1, bq, dq, 5);
    wr(32'h88, 32'd0, e);
    rdreg(32'h88, v);
    tests++;
    if (v !== 32'd2) begin fails++; $display("FAIL bauddiv clamp: got %0d want 2", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int e0, e, start, bad;
    wr(32'h88, 32'd4, e);
    wr(32'h80, 32'h00, e0);
    wr(32'h80, 32'hA5, e);
    wr(32'h80, 32'h3C, e);
    wait_cyc(e0 + 12);
    #2;
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL mid-frame line: tx=%b want 0", tx); end
    reset = 1'b1;
    #1;
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL async reset tx: tx=%b want 1", tx); end
    @(negedge clk);
    reset = 1'b0;
    start = cyc;
    rdreg(32'h84, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL reset-mid status: got %h want 2", v); end
    repeat (120) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 110; k++) if (txlog[start+k] !== 1'b1) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset-mid line: %0d low cycles, want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_back_to_back;
    test_overflow;
    test_divchange;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
